// File: rtl/hazard_scheduler.sv
// Pipeline sequencing: stage tags, load-use bubbles, data-memory handshake.
// Optional stall counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scheduler #(
  parameter int RS_W   = 5,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RS_W-1:0] id_rs1,
  input  logic [RS_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RS_W-1:0] id_rd,
  input  logic            id_reg_we,
  input  logic            id_is_load,
  input  logic            id_is_store,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  output logic            stall,
  output logic            bubble,
  output logic [RS_W-1:0] ex_rd,
  output logic [RS_W-1:0] mem_req_rd,
  output logic [RS_W-1:0] mem_resp_rd,
  output logic [RS_W-1:0] wb_rd,
  output logic            ex_reg_we,
  output logic            mem_req_reg_we,
  output logic            mem_resp_reg_we,
  output logic            wb_reg_we
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_load,
  output logic [PERF_W-1:0] stall_cnt_mem
`endif
);

  typedef struct packed {
    logic            valid;
    logic [RS_W-1:0] rd;
    logic            we;
    logic            is_load;
    logic            is_store;
  } tag_t;

  tag_t r_ex, r_mr, r_rsp, r_wb;
  logic r_req_done;

  tag_t w_id_tag;
  tag_t w_ex_nx, w_mr_nx, w_rsp_nx, w_wb_nx;
  logic w_req_done_nx;
  logic w_mem_hold;
  logic w_load_use;
  logic w_req_hs;
  logic w_mr_mem;
  logic w_rs1_hit, w_rs2_hit;

  function automatic logic ld_hit(
    input tag_t            t,
    input logic [RS_W-1:0] rs
  );
    return t.valid & t.is_load & (t.rd == rs);
  endfunction

  assign w_id_tag = '{
    valid:    id_valid,
    rd:       id_rd,
    we:       id_reg_we,
    is_load:  id_is_load,
    is_store: id_is_store
  };

  assign w_mr_mem = r_mr.valid
                  & (r_mr.is_load | r_mr.is_store);

  assign mem_req_valid = w_mr_mem & ~r_req_done;
  assign w_req_hs = mem_req_valid & mem_req_ready;

  // Stores retire at acceptance; only loads wait on the response.
  assign w_mem_hold =
      (w_mr_mem & ~r_req_done & ~mem_req_ready)
    | (r_rsp.valid & r_rsp.is_load & ~mem_resp_valid);

  // A load in wb is visible through the writeback value already.
  assign w_rs1_hit = id_rs1_used & (id_rs1 != '0)
                   & (ld_hit(r_ex, id_rs1)
                    | ld_hit(r_mr, id_rs1)
                    | ld_hit(r_rsp, id_rs1));

  assign w_rs2_hit = id_rs2_used & (id_rs2 != '0)
                   & (ld_hit(r_ex, id_rs2)
                    | ld_hit(r_mr, id_rs2)
                    | ld_hit(r_rsp, id_rs2));

  assign w_load_use = id_valid & (w_rs1_hit | w_rs2_hit);

  assign stall  = w_mem_hold | w_load_use;
  assign bubble = w_load_use & ~w_mem_hold;

  always_comb begin
    w_ex_nx       = r_ex;
    w_mr_nx       = r_mr;
    w_rsp_nx      = r_rsp;
    w_wb_nx       = r_wb;
    w_req_done_nx = r_req_done;
    unique case (1'b1)
      w_mem_hold: begin
        w_req_done_nx = r_req_done | w_req_hs;
      end
      default: begin
        w_wb_nx       = r_rsp;
        w_rsp_nx      = r_mr;
        w_mr_nx       = r_ex;
        w_ex_nx       = w_load_use ? '0 : w_id_tag;
        w_req_done_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex       <= '0;
      r_mr       <= '0;
      r_rsp      <= '0;
      r_wb       <= '0;
      r_req_done <= 1'b0;
    end else begin
      r_ex       <= w_ex_nx;
      r_mr       <= w_mr_nx;
      r_rsp      <= w_rsp_nx;
      r_wb       <= w_wb_nx;
      r_req_done <= w_req_done_nx;
    end
  end

  assign ex_rd       = r_ex.rd;
  assign mem_req_rd  = r_mr.rd;
  assign mem_resp_rd = r_rsp.rd;
  assign wb_rd       = r_wb.rd;

  assign ex_reg_we = r_ex.valid & r_ex.we
                   & (r_ex.rd != '0);
  assign mem_req_reg_we = r_mr.valid & r_mr.we
                        & (r_mr.rd != '0);
  assign mem_resp_reg_we = r_rsp.valid & r_rsp.we
                         & (r_rsp.rd != '0);
  assign wb_reg_we = r_wb.valid & r_wb.we
                   & (r_wb.rd != '0);

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_cnt_load;
  logic [PERF_W-1:0] r_cnt_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_load <= '0;
      r_cnt_mem  <= '0;
    end else begin
      if (bubble)
        r_cnt_load <= r_cnt_load + 1'b1;
      if (w_mem_hold)
        r_cnt_mem <= r_cnt_mem + 1'b1;
    end
  end

  assign stall_cnt_load = r_cnt_load;
  assign stall_cnt_mem  = r_cnt_mem;
`else
  localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: load-use, memory holds, reset.
// Counter checks are included when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       id_rs1_used, id_rs2_used;
  logic [4:0] id_rd;
  logic       id_reg_we;
  logic       id_is_load, id_is_store;
  logic       mem_req_valid;
  logic       mem_req_ready;
  logic       mem_resp_valid;
  logic       stall, bubble;
  logic [4:0] ex_rd, mem_req_rd;
  logic [4:0] mem_resp_rd, wb_rd;
  logic       ex_reg_we, mem_req_reg_we;
  logic       mem_resp_reg_we, wb_reg_we;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_load;
  logic [31:0] stall_cnt_mem;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.RS_W(5), .PERF_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_reg_we       (id_reg_we),
    .id_is_load      (id_is_load),
    .id_is_store     (id_is_store),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .stall           (stall),
    .bubble          (bubble),
    .ex_rd           (ex_rd),
    .mem_req_rd      (mem_req_rd),
    .mem_resp_rd     (mem_resp_rd),
    .wb_rd           (wb_rd),
    .ex_reg_we       (ex_reg_we),
    .mem_req_reg_we  (mem_req_reg_we),
    .mem_resp_reg_we (mem_resp_reg_we),
    .wb_reg_we       (wb_reg_we)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_load  (stall_cnt_load),
    .stall_cnt_mem   (stall_cnt_mem)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd       = '0;
    id_reg_we   = 1'b0;
    id_is_load  = 1'b0;
    id_is_store = 1'b0;
  endtask

  task automatic lw(input logic [4:0] rd,
                    input logic [4:0] rs1);
    idle();
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs1_used = 1'b1;
    id_rd       = rd;
    id_reg_we   = 1'b1;
    id_is_load  = 1'b1;
  endtask

  task automatic alu(input logic [4:0] rd,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2);
    idle();
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = 1'b1;
    id_rs2_used = 1'b1;
    id_rd       = rd;
    id_reg_we   = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain();
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_bubble"}, bubble, 0);
    chk({tag, "_mrv"}, mem_req_valid, 0);
    chk({tag, "_ex_we"}, ex_reg_we, 0);
    chk({tag, "_mr_we"}, mem_req_reg_we, 0);
    chk({tag, "_rsp_we"}, mem_resp_reg_we, 0);
    chk({tag, "_wb_we"}, wb_reg_we, 0);
    chk({tag, "_ex_rd"}, ex_rd, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    idle();
    step(); #1;
    chk_quiet("rst");
    step();
    rst_n = 1'b1;

    // lw x5 ; add x6,x5,x1
    step(); lw(5'd5, 5'd1); #1;
    chk("s1c0_stall", stall, 0);
    step(); alu(5'd6, 5'd5, 5'd1); #1;
    chk("s1c1_stall", stall, 1);
    chk("s1c1_bubble", bubble, 1);
    chk("s1c1_ex_rd", ex_rd, 5);
    chk("s1c1_ex_we", ex_reg_we, 1);
    chk("s1c1_mrv", mem_req_valid, 0);
    step(); #1;
    chk("s1c2_stall", stall, 1);
    chk("s1c2_bubble", bubble, 1);
    chk("s1c2_mrv", mem_req_valid, 1);
    chk("s1c2_mr_rd", mem_req_rd, 5);
    chk("s1c2_ex_we", ex_reg_we, 0);
    step(); #1;
    chk("s1c3_stall", stall, 1);
    chk("s1c3_bubble", bubble, 1);
    chk("s1c3_rsp_rd", mem_resp_rd, 5);
    chk("s1c3_rsp_we", mem_resp_reg_we, 1);
    step(); #1;
    chk("s1c4_stall", stall, 0);
    chk("s1c4_wb_rd", wb_rd, 5);
    chk("s1c4_wb_we", wb_reg_we, 1);
    step(); idle(); #1;
    chk("s1c5_ex_rd", ex_rd, 6);
    chk("s1c5_ex_we", ex_reg_we, 1);
    drain();

    // addi x5 ; add x6,x5,x5 ; add x6,x5,x5
    alu(5'd5, 5'd1, 5'd0); #1;
    chk("s2c0_stall", stall, 0);
    step(); alu(5'd6, 5'd5, 5'd5); #1;
    chk("s2c1_stall", stall, 0);
    chk("s2c1_ex_rd", ex_rd, 5);
    chk("s2c1_ex_we", ex_reg_we, 1);
    step(); #1;
    chk("s2c2_stall", stall, 0);
    chk("s2c2_ex_rd", ex_rd, 6);
    chk("s2c2_mr_rd", mem_req_rd, 5);
    drain();

    // lw x7 with ready low for 3 cycles
    lw(5'd7, 5'd1); #1;
    chk("s3c0_stall", stall, 0);
    step(); idle(); mem_req_ready = 1'b0; #1;
    chk("s3c1_stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("s3_hold_stall", stall, 1);
      chk("s3_hold_bubble", bubble, 0);
      chk("s3_hold_mrv", mem_req_valid, 1);
      chk("s3_hold_mr_rd", mem_req_rd, 7);
    end
    step(); mem_req_ready = 1'b1; #1;
    chk("s3c5_stall", stall, 0);
    chk("s3c5_mrv", mem_req_valid, 1);
    step(); #1;
    chk("s3c6_rsp_rd", mem_resp_rd, 7);
    chk("s3c6_mrv", mem_req_valid, 0);
    chk("s3c6_stall", stall, 0);
    drain();

    // lw x10 accepted while lw x9 waits for response
    mem_resp_valid = 1'b0;
    lw(5'd9, 5'd1); #1;
    step(); lw(5'd10, 5'd1); #1;
    chk("s4c1_stall", stall, 0);
    step(); idle(); #1;
    chk("s4c2_mrv", mem_req_valid, 1);
    chk("s4c2_stall", stall, 0);
    step(); #1;
    chk("s4c3_stall", stall, 1);
    chk("s4c3_mrv", mem_req_valid, 1);
    chk("s4c3_mr_rd", mem_req_rd, 10);
    n_hs += int'(mem_req_valid & mem_req_ready);
    step(); #1;
    chk("s4c4_stall", stall, 1);
    chk("s4c4_mrv", mem_req_valid, 0);
    chk("s4c4_req_done", dut.r_req_done, 1);
    n_hs += int'(mem_req_valid & mem_req_ready);
    step(); mem_resp_valid = 1'b1; #1;
    chk("s4c5_stall", stall, 0);
    chk("s4c5_mrv", mem_req_valid, 0);
    n_hs += int'(mem_req_valid & mem_req_ready);
    chk("s4_handshakes", n_hs, 1);
    step(); #1;
    chk("s4c6_rsp_rd", mem_resp_rd, 10);
    chk("s4c6_wb_rd", wb_rd, 9);
    chk("s4c6_stall", stall, 0);
    drain();

    // lw x0 ; add x1,x0,x0
    lw(5'd0, 5'd1); #1;
    step(); alu(5'd1, 5'd0, 5'd0); #1;
    chk("s5c1_stall", stall, 0);
    chk("s5c1_ex_rd", ex_rd, 0);
    chk("s5c1_ex_we", ex_reg_we, 0);
    drain();

    // reset pulsed during a load-use stall
    lw(5'd5, 5'd1); #1;
    step(); alu(5'd6, 5'd5, 5'd1); #1;
    chk("s6_pre_stall", stall, 1);
    rst_n = 1'b0; #1;
    chk_quiet("s6_rst");
    chk("s6_rst_mr_rd", mem_req_rd, 0);
    chk("s6_rst_rsp_rd", mem_resp_rd, 0);
    step(); idle();
    step(); rst_n = 1'b1; #1;
    chk("s6_post_stall", stall, 0);

`ifdef HAZARD_PERF_CNT_EN
    step(); lw(5'd5, 5'd1); #1;
    step(); alu(5'd6, 5'd5, 5'd1); #1;
    step(); mem_req_ready = 1'b0; #1;
    chk("p_hold_bubble", bubble, 0);
    step(); #1;
    step(); mem_req_ready = 1'b1; #1;
    step(); #1;
    step(); idle(); #1;
    chk("p_cnt_load", stall_cnt_load, 3);
    chk("p_cnt_mem", stall_cnt_mem, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
